// File: rtl/stream_serializer.sv
// stream_serializer: accepts one DATA_WIDTH word and emits it as RATIO
// beats of OUT_WIDTH bits, least-significant slice first, with a
// valid/ready handshake on both sides and zero-bubble back-to-back words.
module stream_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_last
);

    localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      beat_idx_q, beat_idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  on_last;
    logic                  in_hs;
    logic                  out_hs;

    // Handshake decode; in_ready is forced low while reset is asserted so
    // nothing can be accepted until the first edge after release.
    always_comb begin
        on_last   = (state_q == S_SEND) && (beat_idx_q == LAST_IDX);
        out_valid = (state_q == S_SEND);
        out_last  = on_last;
        in_ready  = rst_n && ((state_q == S_IDLE) || (on_last && out_ready));
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
    end

    // Beat select: constant-index mux over the captured word.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (beat_idx_q == IDX_W'(i)) begin
                out_data = word_q[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // Next-state: capture in IDLE, step through beats in SEND, and on the
    // last beat either reload a new word (no bubble) or fall back to IDLE.
    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        word_d     = word_q;
        case (state_q)
            S_IDLE: begin
                if (in_hs) begin
                    state_d    = S_SEND;
                    beat_idx_d = '0;
                    word_d     = in_data;
                end
            end
            default: begin
                if (out_hs) begin
                    if (beat_idx_q != LAST_IDX) begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end else if (in_hs) begin
                        beat_idx_d = '0;
                        word_d     = in_data;
                    end else begin
                        state_d    = S_IDLE;
                        beat_idx_d = '0;
                    end
                end
            end
        endcase
    end

    // State, beat counter and captured word; reset clears everything so
    // out_data reads zero and any partial word is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            beat_idx_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            word_q     <= word_d;
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Testbench for stream_serializer: vector table for the 8-bit beat
// configuration, hand sequences for reset and the 16-bit configuration,
// and a randomised handshake stress run against a beat queue.
module tb_stream_serializer;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_last;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        iv8, ir8, or8, ov8, ol8;
    logic [31:0] id8;
    logic [7:0]  od8;
    logic        iv16, ir16, or16, ov16, ol16;
    logic [31:0] id16;
    logic [15:0] od16;

    int checks;
    int errors;
    vec_t vq[$];

    stream_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_last(ol8)
    );

    stream_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16), .in_data(id16),
        .out_valid(ov16), .out_ready(or16), .out_data(od16), .out_last(ol16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [7:0] e_od,
                       input logic e_last);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_last = e_last;
        vq.push_back(v);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic       exp_l[$];
        logic       hs_prev;
        int         words;
        int         cyc;
        logic [7:0] eb;
        logic       el;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        iv8 = 0; id8 = '0; or8 = 0;
        iv16 = 0; id16 = '0; or16 = 0;

        // single word 0x12345678
        add(1, 32'h12345678, 1, 1, 0, 8'h00, 0);
        add(0, 32'h0, 1, 0, 1, 8'h78, 0);
        add(0, 32'h0, 1, 0, 1, 8'h56, 0);
        add(0, 32'h0, 1, 0, 1, 8'h34, 0);
        add(0, 32'h0, 1, 1, 1, 8'h12, 1);
        // backpressure on beat 1 of 0xA5A5A5A5, input ignored mid-word
        add(1, 32'hA5A5A5A5, 1, 1, 0, 8'h00, 0);
        add(0, 32'h0, 1, 0, 1, 8'hA5, 0);
        add(1, 32'hFFFFFFFF, 0, 0, 1, 8'hA5, 0);
        add(1, 32'hFFFFFFFF, 0, 0, 1, 8'hA5, 0);
        add(1, 32'hFFFFFFFF, 0, 0, 1, 8'hA5, 0);
        add(0, 32'h0, 1, 0, 1, 8'hA5, 0);
        add(0, 32'h0, 1, 0, 1, 8'hA5, 0);
        add(0, 32'h0, 1, 1, 1, 8'hA5, 1);
        // back-to-back 0x1 then 0x2
        add(1, 32'h1, 1, 1, 0, 8'h00, 0);
        add(1, 32'h2, 1, 0, 1, 8'h01, 0);
        add(1, 32'h2, 1, 0, 1, 8'h00, 0);
        add(1, 32'h2, 1, 0, 1, 8'h00, 0);
        add(1, 32'h2, 1, 1, 1, 8'h00, 1);
        add(0, 32'h0, 1, 0, 1, 8'h02, 0);
        add(0, 32'h0, 1, 0, 1, 8'h00, 0);
        add(0, 32'h0, 1, 0, 1, 8'h00, 0);
        add(0, 32'h0, 1, 1, 1, 8'h00, 1);
        // stall on the last beat blocks a pending input word
        add(1, 32'h11223344, 0, 1, 0, 8'h00, 0);
        add(0, 32'h0, 1, 0, 1, 8'h44, 0);
        add(0, 32'h0, 1, 0, 1, 8'h33, 0);
        add(0, 32'h0, 1, 0, 1, 8'h22, 0);
        add(1, 32'h99999999, 0, 0, 1, 8'h11, 1);
        add(0, 32'h0, 1, 1, 1, 8'h11, 1);
        add(0, 32'h0, 1, 1, 0, 8'h00, 0);

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(ir8), 32'd0);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_out_data", 32'(od8), 32'd0);
        chk("rst_out_last", 32'(ol8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(ir8), 32'd1);
        chk("rel_in_ready16", 32'(ir16), 32'd1);

        // vector table
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            iv8 = vq[i].iv; id8 = vq[i].id; or8 = vq[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(ir8), 32'(vq[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), 32'(ov8), 32'(vq[i].e_ov));
            chk($sformatf("vec%0d_out_last", i), 32'(ol8), 32'(vq[i].e_last));
            if (vq[i].e_ov) chk($sformatf("vec%0d_out_data", i), 32'(od8), 32'(vq[i].e_od));
        end

        // reset asserted mid-word of 0xDEADBEEF
        @(negedge clk);
        iv8 = 1; id8 = 32'hDEADBEEF; or8 = 1;
        @(negedge clk);
        iv8 = 0;
        #1;
        chk("mid_beat0", 32'(od8), 32'hEF);
        @(negedge clk);
        #1;
        chk("mid_beat1", 32'(od8), 32'hBE);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(ov8), 32'd0);
        chk("mid_rst_out_data", 32'(od8), 32'd0);
        chk("mid_rst_in_ready", 32'(ir8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst_idle%0d", i), 32'(ov8), 32'd0);
        end
        @(negedge clk);
        iv8 = 1; id8 = 32'h00000055;
        #1;
        chk("post_rst_in_ready", 32'(ir8), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            iv8 = 0;
            #1;
            chk($sformatf("post_rst_valid%0d", i), 32'(ov8), 32'd1);
            chk($sformatf("post_rst_data%0d", i), 32'(od8), (i == 0) ? 32'h55 : 32'h00);
            chk($sformatf("post_rst_last%0d", i), 32'(ol8), (i == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        #1;
        chk("post_rst_done", 32'(ov8), 32'd0);

        // 16-bit beats
        @(negedge clk);
        iv16 = 1; id16 = 32'hCAFEF00D; or16 = 1;
        #1;
        chk("w16_in_ready", 32'(ir16), 32'd1);
        @(negedge clk);
        iv16 = 0;
        #1;
        chk("w16_beat0", 32'(od16), 32'hF00D);
        chk("w16_last0", 32'(ol16), 32'd0);
        chk("w16_ir0", 32'(ir16), 32'd0);
        @(negedge clk);
        #1;
        chk("w16_beat1", 32'(od16), 32'hCAFE);
        chk("w16_last1", 32'(ol16), 32'd1);
        chk("w16_ir1", 32'(ir16), 32'd1);
        @(negedge clk);
        #1;
        chk("w16_done", 32'(ov16), 32'd0);

        // random handshake stress, 1000 words
        words = 0;
        cyc = 0;
        hs_prev = 0;
        iv8 = 0;
        while (words < 1000 && cyc < 20000) begin
            @(negedge clk);
            if (hs_prev) iv8 = 0;
            if (!iv8) begin
                iv8 = ($urandom_range(0, 2) != 0);
                id8 = $urandom();
            end
            or8 = ($urandom_range(0, 3) != 0);
            #1;
            hs_prev = iv8 && ir8;
            if (ov8 && or8) begin
                if (exp_q.size() == 0) begin
                    chk("stress_unexpected_beat", 32'(ov8), 32'd0);
                end else begin
                    eb = exp_q.pop_front();
                    el = exp_l.pop_front();
                    chk("stress_data", 32'(od8), 32'(eb));
                    chk("stress_last", 32'(ol8), 32'(el));
                end
            end
            if (hs_prev) begin
                for (int b = 0; b < 4; b++) begin
                    exp_q.push_back(id8[b*8 +: 8]);
                    exp_l.push_back(b == 3);
                end
                words++;
            end
            cyc++;
        end
        if (words < 1000) chk("stress_timeout_words", 32'(words), 32'd1000);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(negedge clk);
            iv8 = 0;
            or8 = 1;
            #1;
            if (ov8) begin
                eb = exp_q.pop_front();
                el = exp_l.pop_front();
                chk("drain_data", 32'(od8), 32'(eb));
                chk("drain_last", 32'(ol8), 32'(el));
            end
            cyc++;
        end
        chk("drain_leftover", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        iv8 = 0;
        #1;
        chk("drain_idle", 32'(ov8), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_serializer.md
STREAM_SERIALIZER -- requirements
Module: stream_serializer

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the input word.
REQ-002 Parameter: OUT_WIDTH, default 8, width of one output beat; DATA_WIDTH SHALL be an integer multiple of OUT_WIDTH with RATIO = DATA_WIDTH/OUT_WIDTH >= 2.
REQ-003 Port: clk  input  1  single clock, all state on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  upstream word valid; fed by the pipeline register's out_valid.
REQ-006 Port: in_ready  output  1  block can accept a word this cycle; drives the pipeline register's out_ready.
REQ-007 Port: in_data  input  DATA_WIDTH  upstream word.
REQ-008 Port: out_valid  output  1  current beat valid.
REQ-009 Port: out_ready  input  1  downstream accepts beat.
REQ-010 Port: out_data  output  OUT_WIDTH  current beat.
REQ-011 Port: out_last  output  1  high on the final beat of each word.

Function
REQ-012 Transfer rule on both sides: a handshake occurs on a rising edge where valid && ready are both 1; no other event moves data.
REQ-013 State machine: IDLE (no word held) and SEND (word held, beat counter beat_idx in 0..RATIO-1).
REQ-014 in_ready SHALL be 1 in IDLE, 1 in SEND when beat_idx == RATIO-1 && out_ready == 1, and 0 otherwise; combinational from state, beat_idx and out_ready only (no dependence on in_valid).
REQ-015 IDLE + input handshake -> SEND, word captured into an internal register, beat_idx = 0, out_valid = 1 from the next cycle (latency 1 cycle, input edge to first beat).
REQ-016 out_data SHALL equal captured word bits [(beat_idx+1)*OUT_WIDTH-1 : beat_idx*OUT_WIDTH], least-significant slice first.
REQ-017 out_last SHALL be 1 exactly when out_valid == 1 and beat_idx == RATIO-1.
REQ-018 SEND + output handshake with beat_idx < RATIO-1 -> beat_idx increments by 1, state unchanged.
REQ-019 SEND + output handshake with beat_idx == RATIO-1 and no input handshake -> IDLE, out_valid = 0, out_last = 0 next cycle.
REQ-020 SEND + output handshake on last beat with simultaneous input handshake -> new word captured, beat_idx = 0, out_valid stays 1; no bubble cycle between words.
REQ-021 While out_valid == 1 and out_ready == 0, out_data, out_last, out_valid and beat_idx SHALL hold unchanged.
REQ-022 Input handshake is impossible mid-word (beat_idx < RATIO-1); in_valid/in_data changes then SHALL have no effect.
REQ-023 Sustained throughput with out_ready held 1 SHALL be one word per RATIO cycles, one beat every cycle.
REQ-024 beat_idx width SHALL be $clog2(RATIO); no wrap beyond RATIO-1 is permitted.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, beat_idx 0, out_valid 0, out_last 0, out_data 0, captured word 0, regardless of clk.
REQ-026 in_ready SHALL be 0 while rst_n is low and 1 on the first cycle after release.
REQ-027 Reset asserted mid-word SHALL discard the remaining beats; no partial word is emitted after release.
REQ-028 Release of rst_n SHALL be synchronous-safe: first handshake accepted no earlier than the first rising edge after release.

Verification
REQ-029 Single word: in_data 0x12345678, out_ready 1 -> beats 0x78,0x56,0x34,0x12 on 4 consecutive cycles, out_last only on 0x12, then out_valid 0.
REQ-030 Backpressure: word 0xA5A5A5A5 then out_ready 0 for 3 cycles on beat 1 -> out_data holds 0xA5, beat_idx holds 1, in_ready 0; completes 4 beats after out_ready returns 1.
REQ-031 Back-to-back: in_valid 1 with 0x00000001 then 0x00000002, out_ready 1 -> 8 beats 01,00,00,00,02,00,00,00 with no gap; in_ready high only on cycles of beats 4 and 8.
REQ-032 Reset mid-word: assert rst_n low after beat 1 of 0xDEADBEEF -> out_valid 0 immediately, no 0xBE/0xDE emitted after release; next word 0x00000055 serialises cleanly.
REQ-033 Parameter sweep: OUT_WIDTH 16 with 0xCAFEF00D -> beats 0xF00D, 0xCAFE, out_last on second; random in_valid/out_ready stress with scoreboard, zero lost or duplicated beats over 1000 words.
